// File: rtl/moving_avg_filter_if.sv
// Stream bundle for the boxcar filter: sample input handshake, averaged output
// handshake and the primed status flag.
interface moving_avg_filter_if #(
  parameter int DATA_W    = 12,
  parameter int LOG2_TAPS = 3
);
  logic                                in_valid;
  logic                                in_ready;
  logic signed [DATA_W-1:0]            in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [DATA_W-1:0]            out_data;
  logic signed [DATA_W+LOG2_TAPS-1:0]  out_sum;
  logic                                primed;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sum, primed
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sum, primed
  );
endinterface

// File: rtl/moving_avg_filter.sv
// Streaming boxcar filter: running sum over the last 2^LOG2_TAPS signed samples,
// one registered average per accepted input, valid/ready on both sides.
module moving_avg_filter #(
  parameter int DATA_W    = 12,
  parameter int LOG2_TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  moving_avg_filter_if.slave   bus
);
  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUM_W = DATA_W + LOG2_TAPS;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic signed [DATA_W-1:0] window_q [TAPS];
  logic [LOG2_TAPS-1:0]     wptr_q;
  logic [LOG2_TAPS-1:0]     count_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_d;
  logic [0:0]               state_q;
  logic [0:0]               state_d;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic signed [SUM_W-1:0]  out_sum_q;
  logic                     accept;

  // Single output register: it may be refilled in the same cycle it drains.
  assign bus.in_ready  = !clear && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;

  assign sum_d = sum_q + SUM_W'($signed(bus.in_data)) - SUM_W'($signed(window_q[wptr_q]));

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.primed    = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    if (state_q == ST_FILL && accept && count_q == LOG2_TAPS'(TAPS - 1))
      state_d = ST_RUN;
  end

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_window
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          window_q[gi] <= '0;
        else if (clear)
          window_q[gi] <= '0;
        else if (accept && wptr_q == LOG2_TAPS'(gi))
          window_q[gi] <= bus.in_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else if (clear) begin
      wptr_q      <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wptr_q      <= wptr_q + LOG2_TAPS'(1);
        sum_q       <= sum_d;
        out_sum_q   <= sum_d;
        // Dropping the low bits of a two's complement sum is a floor division.
        out_data_q  <= sum_d[SUM_W-1:LOG2_TAPS];
        out_valid_q <= 1'b1;
        if (state_q == ST_FILL)
          count_q <= count_q + LOG2_TAPS'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
